// File: rtl/fetch_wf_retire.sv
// Wavefront retire tracker. It tracks occupied slots and their dispatcher tags, queues
// finished wavefronts, and returns each completion tag over a valid/ack handshake.
module fetch_wf_retire #(
    parameter int WF_PER_CU     = 40,
    parameter int WF_ID_LENGTH  = 6,
    parameter int WF_TAG_LENGTH = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dispatch_wf_en,
    input  logic [WF_ID_LENGTH-1:0]  dispatch_wf_id,
    input  logic [WF_TAG_LENGTH-1:0] dispatch_wf_tag,
    input  logic                     fetchwave_wf_done_en,
    input  logic [WF_ID_LENGTH-1:0]  fetchwave_wf_done_wf_id,
    input  logic                     dispatch2cu_wf_done_ack,
    output logic                     cu2dispatch_wf_done,
    output logic [WF_TAG_LENGTH-1:0] cu2dispatch_wf_tag_done,
    output logic [WF_PER_CU-1:0]     wf_slot_busy,
    output logic                     wf_retire_err
);

    logic [WF_PER_CU-1:0]     r_busy;
    logic [WF_PER_CU-1:0]     r_pending;
    logic [WF_TAG_LENGTH-1:0] r_tag [WF_PER_CU];
    logic                     r_valid;
    logic [WF_ID_LENGTH-1:0]  r_out_id;
    logic [WF_TAG_LENGTH-1:0] r_out_tag;
    logic [WF_ID_LENGTH-1:0]  r_rr;
    logic                     r_err;

    logic                     w_disp_in_range;
    logic                     w_done_in_range;
    logic                     w_alloc_ok;
    logic                     w_alloc_err;
    logic                     w_done_ok;
    logic                     w_done_err;
    logic                     w_ack;
    logic                     w_load;
    logic                     w_any;
    logic [WF_ID_LENGTH-1:0]  w_sel;
    logic [WF_ID_LENGTH-1:0]  w_rr_next;

    assign w_disp_in_range = 32'(dispatch_wf_id) < 32'(WF_PER_CU);
    assign w_done_in_range = 32'(fetchwave_wf_done_wf_id) < 32'(WF_PER_CU);

    // A slot stays busy through its ack cycle, so a same-cycle re-dispatch is rejected.
    assign w_alloc_ok  = dispatch_wf_en && w_disp_in_range && !r_busy[dispatch_wf_id];
    assign w_alloc_err = dispatch_wf_en && !w_alloc_ok;

    assign w_done_ok   = fetchwave_wf_done_en && w_done_in_range
                         && r_busy[fetchwave_wf_done_wf_id]
                         && !r_pending[fetchwave_wf_done_wf_id]
                         && !(r_valid && (r_out_id == fetchwave_wf_done_wf_id));
    assign w_done_err  = fetchwave_wf_done_en && !w_done_ok;

    assign w_ack  = r_valid && dispatch2cu_wf_done_ack;
    assign w_load = w_any && (!r_valid || dispatch2cu_wf_done_ack);

    // Round-robin pick: first registered pending bit at or after r_rr, wrapping.
    always_comb begin
        int unsigned idx;
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned i = 0; i < WF_PER_CU; i++) begin
            idx = 32'(r_rr) + i;
            if (idx >= WF_PER_CU) idx = idx - WF_PER_CU;
            if (!w_any && r_pending[idx]) begin
                w_any = 1'b1;
                w_sel = WF_ID_LENGTH'(idx);
            end
        end
    end

    assign w_rr_next = (32'(w_sel) == WF_PER_CU - 1) ? '0 : w_sel + WF_ID_LENGTH'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy    <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_out_id  <= '0;
            r_out_tag <= '0;
            r_rr      <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_alloc_ok) r_busy[dispatch_wf_id] <= 1'b1;
            if (w_ack)      r_busy[r_out_id] <= 1'b0;
            if (w_done_ok)  r_pending[fetchwave_wf_done_wf_id] <= 1'b1;
            if (w_load) begin
                r_pending[w_sel] <= 1'b0;
                r_valid          <= 1'b1;
                r_out_id         <= w_sel;
                r_out_tag        <= r_tag[w_sel];
                r_rr             <= w_rr_next;
            end else if (w_ack) begin
                r_valid <= 1'b0;
            end
            if (w_alloc_err || w_done_err) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_ok) r_tag[dispatch_wf_id] <= dispatch_wf_tag;
    end

    assign cu2dispatch_wf_done     = r_valid;
    assign cu2dispatch_wf_tag_done = r_out_tag;
    assign wf_slot_busy            = r_busy;
    assign wf_retire_err           = r_err;

endmodule

// File: tb/tb_fetch_wf_retire.sv
// Directed bench for fetch_wf_retire: reset, retire latency, round-robin wrap,
// backpressure, protocol errors and same-cycle interactions.
module tb_fetch_wf_retire;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dispatch_wf_en = 1'b0;
    logic [5:0]  dispatch_wf_id = '0;
    logic [14:0] dispatch_wf_tag = '0;
    logic        fetchwave_wf_done_en = 1'b0;
    logic [5:0]  fetchwave_wf_done_wf_id = '0;
    logic        dispatch2cu_wf_done_ack = 1'b0;
    logic        cu2dispatch_wf_done;
    logic [14:0] cu2dispatch_wf_tag_done;
    logic [39:0] wf_slot_busy;
    logic        wf_retire_err;

    int n_cmp = 0;
    int n_fail = 0;

    fetch_wf_retire #(.WF_PER_CU(40), .WF_ID_LENGTH(6), .WF_TAG_LENGTH(15)) dut (
        .clk(clk),
        .rst(rst),
        .dispatch_wf_en(dispatch_wf_en),
        .dispatch_wf_id(dispatch_wf_id),
        .dispatch_wf_tag(dispatch_wf_tag),
        .fetchwave_wf_done_en(fetchwave_wf_done_en),
        .fetchwave_wf_done_wf_id(fetchwave_wf_done_wf_id),
        .dispatch2cu_wf_done_ack(dispatch2cu_wf_done_ack),
        .cu2dispatch_wf_done(cu2dispatch_wf_done),
        .cu2dispatch_wf_tag_done(cu2dispatch_wf_tag_done),
        .wf_slot_busy(wf_slot_busy),
        .wf_retire_err(wf_retire_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic disp(input int id, input int tag);
        dispatch_wf_en  = 1'b1;
        dispatch_wf_id  = 6'(id);
        dispatch_wf_tag = 15'(tag);
        cyc();
        dispatch_wf_en  = 1'b0;
    endtask

    task automatic done(input int id);
        fetchwave_wf_done_en    = 1'b1;
        fetchwave_wf_done_wf_id = 6'(id);
        cyc();
        fetchwave_wf_done_en    = 1'b0;
    endtask

    function automatic logic [39:0] bits(input int a, input int b);
        logic [39:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        // Reset state
        #2 rst = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 64'(cu2dispatch_wf_done), 64'd0);
        chk("rst_tag", 64'(cu2dispatch_wf_tag_done), 64'd0);
        chk("rst_busy", 64'(wf_slot_busy), 64'd0);
        chk("rst_err", 64'(wf_retire_err), 64'd0);
        rst = 1'b1;
        cyc();

        // Single retire: slot 5 tag 0x1234
        disp(5, 'h1234);
        chk("t1_busy", 64'(wf_slot_busy), 64'(bits(5, -1)));
        cyc();
        cyc();
        done(5);
        chk("t1_pend_not_yet_valid", 64'(cu2dispatch_wf_done), 64'd0);
        cyc();
        chk("t1_valid", 64'(cu2dispatch_wf_done), 64'd1);
        chk("t1_tag", 64'(cu2dispatch_wf_tag_done), 64'h1234);
        cyc();
        chk("t1_hold_valid", 64'(cu2dispatch_wf_done), 64'd1);
        chk("t1_hold_busy", 64'(wf_slot_busy), 64'(bits(5, -1)));
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("t1_after_ack_valid", 64'(cu2dispatch_wf_done), 64'd0);
        chk("t1_after_ack_busy", 64'(wf_slot_busy), 64'd0);

        // Round-robin wrap: retire 7 to move rr to 8, then 3 and 39 queue behind it
        disp(7, 'h0700);
        done(7);
        cyc();
        chk("rr_first7", 64'(cu2dispatch_wf_tag_done), 64'h0700);
        disp(3, 'h0303);
        disp(39, 'h3939);
        done(3);
        done(39);
        chk("rr_held7_valid", 64'(cu2dispatch_wf_done), 64'd1);
        chk("rr_held7_tag", 64'(cu2dispatch_wf_tag_done), 64'h0700);
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        chk("rr_emit39", 64'(cu2dispatch_wf_tag_done), 64'h3939);
        chk("rr_busy_a", 64'(wf_slot_busy), 64'(bits(3, 39)));
        disp(7, 'h0777);
        chk("rr_emit3", 64'(cu2dispatch_wf_tag_done), 64'h0303);
        chk("rr_busy_b", 64'(wf_slot_busy), 64'(bits(3, 7)));
        done(7);
        chk("rr_same_cycle_done_not_loaded", 64'(cu2dispatch_wf_done), 64'd0);
        cyc();
        chk("rr_emit7_valid", 64'(cu2dispatch_wf_done), 64'd1);
        chk("rr_emit7", 64'(cu2dispatch_wf_tag_done), 64'h0777);
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("rr_drain_valid", 64'(cu2dispatch_wf_done), 64'd0);
        chk("rr_drain_busy", 64'(wf_slot_busy), 64'd0);

        // Backpressure: slot 1 held five cycles, slot 2 follows back-to-back
        disp(1, 'h0011);
        disp(2, 'h0022);
        done(1);
        done(2);
        chk("bp_first", 64'(cu2dispatch_wf_tag_done), 64'h0011);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_stable_tag", 64'(cu2dispatch_wf_tag_done), 64'h0011);
            chk("bp_stable_valid", 64'(cu2dispatch_wf_done), 64'd1);
        end
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("bp_second_valid", 64'(cu2dispatch_wf_done), 64'd1);
        chk("bp_second_tag", 64'(cu2dispatch_wf_tag_done), 64'h0022);
        chk("bp_busy", 64'(wf_slot_busy), 64'(bits(2, -1)));
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("bp_drain", 64'(cu2dispatch_wf_done), 64'd0);
        chk("bp_err_clean", 64'(wf_retire_err), 64'd0);

        // Errors: idle done, busy re-dispatch, duplicate done
        done(10);
        cyc();
        chk("err_idle_no_out", 64'(cu2dispatch_wf_done), 64'd0);
        chk("err_idle_flag", 64'(wf_retire_err), 64'd1);
        disp(4, 'h0444);
        disp(4, 'h7fff);
        done(4);
        done(4);
        chk("err_tag_unchanged", 64'(cu2dispatch_wf_tag_done), 64'h0444);
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("err_ack_drop", 64'(cu2dispatch_wf_done), 64'd0);
        cyc();
        cyc();
        chk("err_single_completion", 64'(cu2dispatch_wf_done), 64'd0);
        chk("err_sticky", 64'(wf_retire_err), 64'd1);
        chk("err_busy", 64'(wf_slot_busy), 64'd0);

        // Mid-traffic asynchronous reset
        disp(9, 'h0999);
        disp(8, 'h0888);
        done(9);
        done(8);
        chk("mr_valid_before", 64'(cu2dispatch_wf_done), 64'd1);
        rst = 1'b0;
        #1;
        chk("mr_valid", 64'(cu2dispatch_wf_done), 64'd0);
        chk("mr_tag", 64'(cu2dispatch_wf_tag_done), 64'd0);
        chk("mr_busy", 64'(wf_slot_busy), 64'd0);
        chk("mr_err", 64'(wf_retire_err), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        chk("mr_pending_discarded", 64'(cu2dispatch_wf_done), 64'd0);

        // Same-cycle: dispatch 6 with done 5; ack 5 with re-dispatch of 5
        disp(5, 'h0505);
        dispatch_wf_en = 1'b1;
        dispatch_wf_id = 6'd6;
        dispatch_wf_tag = 15'h0606;
        fetchwave_wf_done_en = 1'b1;
        fetchwave_wf_done_wf_id = 6'd5;
        cyc();
        dispatch_wf_en = 1'b0;
        fetchwave_wf_done_en = 1'b0;
        chk("sc_busy_both", 64'(wf_slot_busy), 64'(bits(5, 6)));
        chk("sc_no_err", 64'(wf_retire_err), 64'd0);
        cyc();
        chk("sc_emit5", 64'(cu2dispatch_wf_tag_done), 64'h0505);
        dispatch2cu_wf_done_ack = 1'b1;
        disp(5, 'h1555);
        dispatch2cu_wf_done_ack = 1'b0;
        chk("sc_ack_valid", 64'(cu2dispatch_wf_done), 64'd0);
        chk("sc_ack_busy", 64'(wf_slot_busy), 64'(bits(6, -1)));
        chk("sc_redispatch_err", 64'(wf_retire_err), 64'd1);
        done(6);
        cyc();
        chk("sc_emit6", 64'(cu2dispatch_wf_tag_done), 64'h0606);
        dispatch2cu_wf_done_ack = 1'b1;
        cyc();
        dispatch2cu_wf_done_ack = 1'b0;
        chk("sc_final_busy", 64'(wf_slot_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_wf_retire.md
# fetch_wf_retire

Fetch-side receiver of the wavefront-done notification produced by the issue stage. Tracks which wavefront slots of the CU are occupied, records the dispatcher tag for each slot at allocation, and, when the issue stage reports a wavefront finished, queues it and returns its tag to the dispatcher over a valid/ack handshake. The slot is freed only once the dispatcher accepts the completion.

## Interface
Parameters:
- WF_PER_CU, 40, number of wavefront slots
- WF_ID_LENGTH, 6, slot index width
- WF_TAG_LENGTH, 15, dispatcher tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- dispatch_wf_en  in  1  allocate a slot this cycle
- dispatch_wf_id  in  WF_ID_LENGTH  slot being allocated
- dispatch_wf_tag  in  WF_TAG_LENGTH  tag stored for that slot
- fetchwave_wf_done_en  in  1  issue stage reports a finished wavefront
- fetchwave_wf_done_wf_id  in  WF_ID_LENGTH  finished slot
- dispatch2cu_wf_done_ack  in  1  dispatcher accepts the current completion
- cu2dispatch_wf_done  out  1  completion valid (registered)
- cu2dispatch_wf_tag_done  out  WF_TAG_LENGTH  tag of completing wavefront (registered)
- wf_slot_busy  out  WF_PER_CU  per-slot occupied flag (registered)
- wf_retire_err  out  1  sticky protocol-error flag (registered)

## Operation
- State: busy[WF_PER_CU], pending[WF_PER_CU], tag table[WF_PER_CU] x WF_TAG_LENGTH, output register (valid, slot id, tag), round-robin pointer rr (0..WF_PER_CU-1), err.
- Allocation: dispatch_wf_en with busy[id]==0 and id<WF_PER_CU -> busy[id]=1, tag[id]=dispatch_wf_tag. If busy[id]==1 (including the slot in its ack cycle) or id>=WF_PER_CU -> ignored, err=1.
- Done: fetchwave_wf_done_en with busy[id]==1, pending[id]==0, slot not held in output register -> pending[id]=1. Otherwise ignored, err=1.
- Selection: first set pending bit scanning rr, rr+1, ..., wrapping 39->0.
- Output load: when output register empty, or valid with ack this cycle, and any pending bit (as registered, not including same-cycle done) is set -> load selected slot: valid=1, tag=tag[slot], pending[slot]=0, rr=(slot+1) mod WF_PER_CU (39 -> 0).
- Handshake: valid, tag stable until ack. Ack while valid -> busy[slot]=0 at that edge; valid drops next cycle unless a new load occurs the same edge. Ack while valid low is ignored.
- Allocation and done for different slots in the same cycle are both processed. Done and dispatch for the same slot in one cycle: dispatch ignored (slot busy), err=1.
- err is cleared only by reset.

## Timing
- Reset (async assert): cu2dispatch_wf_done=0, cu2dispatch_wf_tag_done=0, wf_slot_busy=0, wf_retire_err=0, pending=0, rr=0; tag table need not be reset. Reset mid-handshake drops valid immediately and discards all pending work.
- Done in cycle t (output idle) -> pending set at end of t -> cu2dispatch_wf_done high in cycle t+1 earliest... specifically: load at end of t+1, valid visible in t+2.
- Dispatch in cycle t -> wf_slot_busy bit high from t+1.
- Ack in cycle k -> wf_slot_busy bit low from k+1; with pending work, next valid visible in k+1 (back-to-back, one completion per cycle throughput with ack tied high).
- No combinational path from any input to any output.

## Test plan
- Reset: hold rst=0 mid-traffic -> all outputs 0 immediately; after release, busy=0, no valid until new dispatch+done.
- Single retire: dispatch slot 5 tag 0x1234 at t=0; done slot 5 at t=3 -> valid with tag 0x1234 at t=5; ack at t=7 -> busy[5]=0 from t=8, valid=0 at t=8.
- Round-robin wrap: slots 3, 7, 39 busy, rr advanced to 8 by prior retire of slot 7 ... then done 3, 7, 39 same window, ack tied 1 -> emitted order 39, 3, 7 (wrap 39->0), rr=8 after.
- Backpressure: two done slots 1 and 2, ack low 5 cycles -> tag of slot 1 stable 5 cycles, slot 2 pending; ack -> slot 2 valid next cycle.
- Errors: done for idle slot 10 -> no output, wf_retire_err=1 sticky; dispatch to busy slot 4 -> tag[4] unchanged, err=1; duplicate done for pending slot -> single completion only.
- Same-cycle: dispatch slot 6 and done slot 5 together -> both take effect; ack slot 5 with dispatch slot 5 same cycle -> dispatch rejected, err=1.
